// File: rtl/regfile_param.sv
// Parametrised DW x 2**AW register file: one byte-strobed write port and two registered read ports.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    input  logic              re_a,
    input  logic [AW-1:0]     raddr_a,
    output logic [DW-1:0]     rdata_a,
    input  logic              re_b,
    input  logic [AW-1:0]     raddr_b,
    output logic [DW-1:0]     rdata_b
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned NB    = DW / 8;

    if (((DW % 8) != 0) || (DW == 0)) begin : g_bad_dw
        $error("regfile_param: DW must be a non-zero multiple of 8");
    end

    logic [DEPTH-1:0][DW-1:0] r_mem;
    logic [DW-1:0]            r_rdata_a;
    logic [DW-1:0]            r_rdata_b;

    logic [DW-1:0]            w_old;
    logic [DW-1:0]            w_merged;
    logic [DW-1:0]            w_rd_a;
    logic [DW-1:0]            w_rd_b;
    logic                     w_zero_wa;
    logic                     w_wr_en;

    // Entry 0 is never written when hardwired, so its storage stays at its reset value of zero.
    assign w_zero_wa = (ZERO_REG != 0) && (waddr == '0);
    assign w_wr_en   = we && (wstrb != '0) && !w_zero_wa;
    assign w_old     = r_mem[waddr];

    for (genvar g = 0; g < NB; g++) begin : g_merge
        assign w_merged[8*g +: 8] = wstrb[g] ? wdata[8*g +: 8] : w_old[8*g +: 8];
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                r_mem[e] <= '0;
            end else if (clr) begin
                r_mem[e] <= '0;
            end else if (w_wr_en && (waddr == AW'(e))) begin
                r_mem[e] <= w_merged;
            end
        end
    end

    // Read-side value; the hardwired-zero rule is applied last so it overrides forwarding.
    always_comb begin
        w_rd_a = r_mem[raddr_a];
        w_rd_b = r_mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (we && (raddr_a == waddr)) begin
            w_rd_a = w_merged;
        end
        if (we && (raddr_b == waddr)) begin
            w_rd_b = w_merged;
        end
`endif
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            w_rd_a = '0;
        end
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            w_rd_b = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else if (clr) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (re_a) begin
                r_rdata_a <= w_rd_a;
            end
            if (re_b) begin
                r_rdata_b <= w_rd_b;
            end
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, hardwired-zero and sweep sequences,
// and randomized traffic against a behavioural array model.
module tb_regfile_param;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // u0: DW=32, AW=3, ZERO_REG=0
    logic        u0_clr, u0_we, u0_re_a, u0_re_b;
    logic [2:0]  u0_waddr, u0_raddr_a, u0_raddr_b;
    logic [31:0] u0_wdata, u0_rdata_a, u0_rdata_b;
    logic [3:0]  u0_wstrb;

    // u1: DW=8, AW=3, ZERO_REG=1
    logic        u1_clr, u1_we, u1_re_a, u1_re_b;
    logic [2:0]  u1_waddr, u1_raddr_a, u1_raddr_b;
    logic [7:0]  u1_wdata, u1_rdata_a, u1_rdata_b;
    logic [0:0]  u1_wstrb;

    // u2: DW=8, AW=4, ZERO_REG=0
    logic        u2_clr, u2_we, u2_re_a, u2_re_b;
    logic [3:0]  u2_waddr, u2_raddr_a, u2_raddr_b;
    logic [7:0]  u2_wdata, u2_rdata_a, u2_rdata_b;
    logic [0:0]  u2_wstrb;

    regfile_param #(.DW(32), .AW(3), .ZERO_REG(0)) u0 (
        .clk(clk), .clr_n(clr_n), .clr(u0_clr), .we(u0_we), .waddr(u0_waddr),
        .wdata(u0_wdata), .wstrb(u0_wstrb), .re_a(u0_re_a), .raddr_a(u0_raddr_a),
        .rdata_a(u0_rdata_a), .re_b(u0_re_b), .raddr_b(u0_raddr_b), .rdata_b(u0_rdata_b)
    );

    regfile_param #(.DW(8), .AW(3), .ZERO_REG(1)) u1 (
        .clk(clk), .clr_n(clr_n), .clr(u1_clr), .we(u1_we), .waddr(u1_waddr),
        .wdata(u1_wdata), .wstrb(u1_wstrb), .re_a(u1_re_a), .raddr_a(u1_raddr_a),
        .rdata_a(u1_rdata_a), .re_b(u1_re_b), .raddr_b(u1_raddr_b), .rdata_b(u1_rdata_b)
    );

    regfile_param #(.DW(8), .AW(4), .ZERO_REG(0)) u2 (
        .clk(clk), .clr_n(clr_n), .clr(u2_clr), .we(u2_we), .waddr(u2_waddr),
        .wdata(u2_wdata), .wstrb(u2_wstrb), .re_a(u2_re_a), .raddr_a(u2_raddr_a),
        .rdata_a(u2_rdata_a), .re_b(u2_re_b), .raddr_b(u2_raddr_b), .rdata_b(u2_rdata_b)
    );

    typedef struct {
        logic        clr;
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        re_a;
        logic [2:0]  ra;
        logic        re_b;
        logic [2:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic clr, input logic we, input logic [2:0] wa,
                                input logic [31:0] wd, input logic [3:0] st,
                                input logic re_a, input logic [2:0] ra,
                                input logic re_b, input logic [2:0] rb,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.clr = clr; v.we = we; v.wa = wa; v.wd = wd; v.st = st;
        v.re_a = re_a; v.ra = ra; v.re_b = re_b; v.rb = rb; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input vec_t v);
        u0_clr = v.clr; u0_we = v.we; u0_waddr = v.wa; u0_wdata = v.wd; u0_wstrb = v.st;
        u0_re_a = v.re_a; u0_raddr_a = v.ra; u0_re_b = v.re_b; u0_raddr_b = v.rb;
    endtask

    task automatic idle0();
        drive0(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic read_all0(input string tag);
        for (int i = 0; i < 8; i++) begin
            u0_re_a = 1'b1; u0_raddr_a = 3'(i);
            u0_re_b = 1'b1; u0_raddr_b = 3'(7 - i);
            tick();
            chk($sformatf("%s_a[%0d]", tag, i), u0_rdata_a, 32'h0);
            chk($sformatf("%s_b[%0d]", tag, 7 - i), u0_rdata_b, 32'h0);
        end
        idle0();
    endtask

    // Model: a word is updated byte by byte wherever the strobe is set.
    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    logic [31:0] m0 [8];
    logic [31:0] ea, eb, va, vb;
    logic [31:0] rdw_exp, part_exp;

    initial begin
        clr_n = 1'b0;
        idle0();
        u1_clr = 0; u1_we = 0; u1_waddr = 0; u1_wdata = 0; u1_wstrb = 0;
        u1_re_a = 0; u1_raddr_a = 0; u1_re_b = 0; u1_raddr_b = 0;
        u2_clr = 0; u2_we = 0; u2_waddr = 0; u2_wdata = 0; u2_wstrb = 0;
        u2_re_a = 0; u2_raddr_a = 0; u2_re_b = 0; u2_raddr_b = 0;
        #12;
        chk("rst_u0_a", u0_rdata_a, 0);
        chk("rst_u0_b", u0_rdata_b, 0);
        chk("rst_u1_a", 32'(u1_rdata_a), 0);
        chk("rst_u2_b", 32'(u2_rdata_b), 0);
        clr_n = 1'b1;

        read_all0("rst_read");

`ifdef REGFILE_BYPASS_EN
        rdw_exp  = 32'h34;
        part_exp = 32'h00005600;
`else
        rdw_exp  = 32'h12;
        part_exp = 32'h0;
`endif
        //            clr we wa  wdata         st     rea ra rebrb  exp_a         exp_b
        tv.push_back(mk(0, 1, 2, 32'h11223344, 4'hF, 0, 0, 0, 0, 32'h0,        32'h0));
        tv.push_back(mk(0, 1, 2, 32'hAABBCCDD, 4'h5, 0, 0, 0, 0, 32'h0,        32'h0));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 1, 2, 0, 0, 32'h11BB33DD, 32'h0));
        tv.push_back(mk(0, 1, 1, 32'h0F,       4'hF, 0, 0, 0, 0, 32'h11BB33DD, 32'h0));
        tv.push_back(mk(0, 1, 6, 32'hF0,       4'hF, 0, 0, 0, 0, 32'h11BB33DD, 32'h0));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 1, 1, 1, 6, 32'h0F,       32'hF0));
        tv.push_back(mk(0, 1, 1, 32'h77,       4'hF, 0, 1, 0, 6, 32'h0F,       32'hF0));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 1, 1, 1, 1, 32'h77,       32'h77));
        tv.push_back(mk(0, 1, 5, 32'h12,       4'hF, 0, 0, 0, 0, 32'h77,       32'h77));
        tv.push_back(mk(0, 1, 5, 32'h34,       4'hF, 1, 5, 0, 0, rdw_exp,      32'h77));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 1, 5, 0, 0, 32'h34,       32'h77));
        tv.push_back(mk(0, 1, 3, 32'hFFFFFFFF, 4'h0, 0, 0, 1, 3, 32'h34,       32'h0));
        tv.push_back(mk(0, 1, 3, 32'h12345678, 4'h2, 0, 0, 1, 3, 32'h34,       part_exp));
        tv.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 0, 1, 3, 32'h34,       32'h00005600));
        tv.push_back(mk(0, 1, 3, 32'hA5,       4'hF, 0, 0, 0, 0, 32'h34,       32'h00005600));
        tv.push_back(mk(1, 1, 4, 32'hCAFEF00D, 4'hF, 1, 3, 1, 5, 32'h0,        32'h0));
        foreach (tv[i]) begin
            drive0(tv[i]);
            tick();
            chk($sformatf("vec%0d_a", i), u0_rdata_a, tv[i].ea);
            chk($sformatf("vec%0d_b", i), u0_rdata_b, tv[i].eb);
        end
        idle0();
        read_all0("clr_read");

        // Hardwired entry 0: writes dropped, reads zero even in the same cycle as a write.
        u1_we = 1; u1_waddr = 0; u1_wdata = 8'hFF; u1_wstrb = 1'b1;
        tick();
        u1_waddr = 7; u1_wdata = 8'h5A;
        u1_re_a = 1; u1_raddr_a = 0; u1_re_b = 1; u1_raddr_b = 0;
        tick();
        chk("zr_a0", 32'(u1_rdata_a), 0);
        chk("zr_b0", 32'(u1_rdata_b), 0);
        u1_waddr = 0; u1_wdata = 8'hFF; u1_raddr_a = 7; u1_raddr_b = 0;
        tick();
        chk("zr_a7", 32'(u1_rdata_a), 32'h5A);
        chk("zr_b0_rdw", 32'(u1_rdata_b), 0);
        u1_raddr_a = 0; u1_raddr_b = 7;
        tick();
        chk("zr_a0_rdw", 32'(u1_rdata_a), 0);
        chk("zr_b7", 32'(u1_rdata_b), 32'h5A);
        u1_we = 0; u1_re_a = 0; u1_re_b = 0;

        // Sweep all 16 entries of the AW=4 instance.
        for (int i = 0; i < 16; i++) begin
            u2_we = 1; u2_waddr = 4'(i); u2_wdata = 8'(i + 1); u2_wstrb = 1'b1;
            tick();
        end
        u2_we = 0;
        for (int i = 0; i < 16; i++) begin
            u2_re_a = 1; u2_raddr_a = 4'(i); u2_re_b = 1; u2_raddr_b = 4'(15 - i);
            tick();
            chk($sformatf("sweep_a[%0d]", i), 32'(u2_rdata_a), 32'(i + 1));
            chk($sformatf("sweep_b[%0d]", 15 - i), 32'(u2_rdata_b), 32'(16 - i));
        end
        u2_re_a = 0; u2_re_b = 0;

        // Randomized traffic on u0; u0 is all-zero with zero read outputs at this point.
        for (int i = 0; i < 8; i++) m0[i] = 32'h0;
        ea = 32'h0; eb = 32'h0;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = mk(($urandom % 25) == 0, 1'($urandom), 3'($urandom), $urandom, 4'($urandom),
                   1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 0, 0);
            if (v.clr) begin
                for (int i = 0; i < 8; i++) m0[i] = 32'h0;
                ea = 32'h0; eb = 32'h0;
            end else begin
                va = m0[v.ra];
                vb = m0[v.rb];
`ifdef REGFILE_BYPASS_EN
                if (v.we && v.ra == v.wa) va = mrg(m0[v.wa], v.wd, v.st);
                if (v.we && v.rb == v.wa) vb = mrg(m0[v.wa], v.wd, v.st);
`endif
                if (v.re_a) ea = va;
                if (v.re_b) eb = vb;
                if (v.we) m0[v.wa] = mrg(m0[v.wa], v.wd, v.st);
            end
            drive0(v);
            tick();
            chk($sformatf("rnd%0d_a", n), u0_rdata_a, ea);
            chk($sformatf("rnd%0d_b", n), u0_rdata_b, eb);
        end

        // Known nonzero outputs, then an asynchronous reset pulse between clock edges.
        drive0(mk(0, 1, 2, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0));
        tick();
        drive0(mk(0, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0));
        tick();
        chk("pre_arst_a", u0_rdata_a, 32'hDEADBEEF);
        chk("pre_arst_b", u0_rdata_b, 32'hDEADBEEF);
        idle0();
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_u0_a", u0_rdata_a, 0);
        chk("arst_u0_b", u0_rdata_b, 0);
        chk("arst_u2_a", 32'(u2_rdata_a), 0);
        chk("arst_u1_a", 32'(u1_rdata_a), 0);
        #1;
        clr_n = 1'b1;
        read_all0("arst_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
